// File: rtl/ones_count_seq.sv
// Multi-cycle population counter: CHUNK bits per clock under a start/busy/done
// handshake, with an optional saturating accumulator and sticky overflow flag.
module ones_count_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int ACC_W = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dat_in,
    input  logic             mode,
    input  logic             clr_acc,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf
);

    localparam int NSTEP = WIDTH / CHUNK;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shift_q;
    logic               mode_q;
    logic [CNT_W-1:0]   partial_q;
    logic [SW-1:0]      step_q;
    logic [CNT_W-1:0]   count_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   psum;
    logic [ACC_W:0]     acc_sum;
    logic               last_step;

    function automatic logic [CNT_W-1:0] pop_chunk(input logic [CHUNK-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    assign psum      = partial_q + pop_chunk(shift_q[CHUNK-1:0]);
    assign last_step = (step_q == SW'(NSTEP - 1));
    // One extra bit catches the true sum exceeding the accumulator range
    assign acc_sum   = {1'b0, acc_q} + (ACC_W + 1)'(count_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE:    busy = 1'b0;
            RUN:     busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            mode_q    <= 1'b0;
            partial_q <= '0;
            step_q    <= '0;
            count_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q   <= dat_in;
                        mode_q    <= mode;
                        partial_q <= '0;
                        step_q    <= '0;
                    end
                end
                RUN: begin
                    shift_q   <= shift_q >> CHUNK;
                    partial_q <= psum;
                    step_q    <= step_q + SW'(1);
                    if (last_step) count_q <= psum;
                end
                default: ;
            endcase
        end
    end

    // Clear takes priority over an accumulate landing on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_acc) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (state == DONE && mode_q) begin
            if (acc_sum[ACC_W]) begin
                acc_q <= '1;
                ovf_q <= 1'b1;
            end else begin
                acc_q <= acc_sum[ACC_W-1:0];
            end
        end
    end

    assign count   = count_q;
    assign acc     = acc_q;
    assign acc_ovf = ovf_q;

endmodule
